alu_stage: RTL and testbench

ALU_STAGE -- requirements
Module: alu_stage

---
 rtl/alu_stage_if.sv | 63 ++++++
 rtl/alu_stage.sv | 196 +++++++++++++++++++
 tb/tb_alu_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_stage_if.sv
// -----------------------------------------------------------------------------
// alu_stage_if -- operand, control and C-bus signals of the ALU stage.
//
// Signals
//   abus_in   operand A
//   bbus_in   operand B (register-file B-bus output)
//   alu_op    operation code, sampled together with start
//   cbus_sel  destination register code, sampled together with start
//   start     operation request, accepted only while the stage is idle
//   cbus_out  result driven onto the C bus
//   cbus_en   C-bus write-enable code (4'b0000 = no write)
//   busy      stage is not idle
//   done      one-cycle pulse marking the write-back cycle
//   err       one-cycle pulse with done for an illegal alu_op
//   z_flag    result == 0 from the last legal write-back
//
// Modports
//   master  the requester (drives operands and start)
//   slave   the ALU stage itself
// -----------------------------------------------------------------------------
interface alu_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] abus_in;
    logic [WIDTH-1:0] bbus_in;
    logic [3:0]       alu_op;
    logic [3:0]       cbus_sel;
    logic             start;
    logic [WIDTH-1:0] cbus_out;
    logic [3:0]       cbus_en;
    logic             busy;
    logic             done;
    logic             err;
    logic             z_flag;

    modport master (
        output abus_in,
        output bbus_in,
        output alu_op,
        output cbus_sel,
        output start,
        input  cbus_out,
        input  cbus_en,
        input  busy,
        input  done,
        input  err,
        input  z_flag
    );

    modport slave (
        input  abus_in,
        input  bbus_in,
        input  alu_op,
        input  cbus_sel,
        input  start,
        output cbus_out,
        output cbus_en,
        output busy,
        output done,
        output err,
        output z_flag
    );
endinterface

// File: rtl/alu_stage.sv
// -----------------------------------------------------------------------------
// alu_stage -- multi-cycle ALU stage writing its result onto the C bus.
//
// Ports
//   clock     single clock, all state updates on its rising edge
//   reset_n   asynchronous, active-low reset
//   bus       alu_stage_if.slave: operands, op/destination codes, start,
//             and the C-bus result, write enable, busy, done, err, z_flag
//
// Operation
//   IDLE + start latches A, B, op and destination. Single-cycle ops go straight
//   to WB. SHR by n > 0 spends n RUN cycles shifting B right one bit per cycle.
//   MUL is shift-and-add, one multiplier bit per RUN cycle, LSB first, WIDTH
//   cycles in total. In WB every output is a register so the C-bus registers,
//   which capture on the falling edge, always see settled values.
//   Illegal ops report err with done, write nothing and leave cbus_out/z_flag.
// -----------------------------------------------------------------------------
module alu_stage #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clock,
    input logic        reset_n,
    alu_stage_if.slave bus
);

    // Wide enough to hold WIDTH, the MUL iteration count.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpPass = 4'b0011;
    localparam logic [3:0] OpShr  = 4'b0100;
    localparam logic [3:0] OpMul  = 4'b0101;
    localparam logic [3:0] OpInc  = 4'b0110;
    localparam logic [3:0] OpClr  = 4'b0111;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWb
    } state_e;

    state_e           state_q, state_d;
    // a_q: MUL multiplicand, shifted left each RUN cycle.
    // b_q: MUL multiplier / SHR operand, shifted right each RUN cycle.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       en_q, en_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             z_q, z_d;

    // Single-cycle result straight from the input buses.
    logic [WIDTH-1:0] imm_res;
    logic             imm_legal;

    // Value produced by the current RUN step (final on the last step).
    logic [WIDTH-1:0] mul_step;
    logic [WIDTH-1:0] shr_step;
    logic [WIDTH-1:0] run_res;

    always_comb begin
        imm_res   = '0;
        imm_legal = 1'b1;
        case (bus.alu_op)
            OpAdd:   imm_res = bus.abus_in + bus.bbus_in;
            OpSub:   imm_res = bus.abus_in - bus.bbus_in;
            OpPass:  imm_res = bus.bbus_in;
            // Only used for a zero shift amount; non-zero shifts go through RUN.
            OpShr:   imm_res = bus.bbus_in;
            OpMul:   imm_res = '0;
            OpInc:   imm_res = bus.abus_in + WIDTH'(1);
            OpClr:   imm_res = '0;
            default: imm_legal = 1'b0;
        endcase
    end

    always_comb begin
        mul_step = b_q[0] ? (acc_q + a_q) : acc_q;
        shr_step = b_q >> 1;
        run_res  = (op_q == OpMul) ? mul_step : shr_step;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        op_d    = op_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        // Pulses and the write enable are only ever high in WB.
        en_d    = 4'b0000;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d   = bus.abus_in;
                    b_d   = bus.bbus_in;
                    op_d  = bus.alu_op;
                    sel_d = bus.cbus_sel;
                    acc_d = '0;
                    if (bus.alu_op == OpMul) begin
                        state_d = StRun;
                        cnt_d   = CntW'(WIDTH);
                    end else if (bus.alu_op == OpShr && bus.abus_in[4:0] != 5'd0) begin
                        state_d = StRun;
                        cnt_d   = CntW'(bus.abus_in[4:0]);
                    end else begin
                        state_d = StWb;
                        done_d  = 1'b1;
                        if (imm_legal) begin
                            out_d = imm_res;
                            en_d  = bus.cbus_sel;
                            z_d   = (imm_res == '0);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                b_d   = shr_step;
                if (op_q == OpMul) begin
                    acc_d = mul_step;
                    a_d   = a_q << 1;
                end
                // Last step: the result goes straight to the output register.
                if (cnt_q == CntW'(1)) begin
                    state_d = StWb;
                    done_d  = 1'b1;
                    out_d   = run_res;
                    en_d    = sel_q;
                    z_d     = (run_res == '0);
                end
            end

            StWb: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            op_q    <= 4'b0000;
            sel_q   <= 4'b0000;
            en_q    <= 4'b0000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            z_q     <= z_d;
        end
    end

    assign bus.cbus_out = out_q;
    assign bus.cbus_en  = en_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.z_flag   = z_q;

endmodule

// File: tb/tb_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_stage -- scoreboard bench for alu_stage. The driver computes each
// expected write-back (value, enable, err, z, cycle) from the operation rules
// and queues it; the monitor pops and compares whenever done is seen, and
// checks hold/idle values and reset values on every other falling edge.
// -----------------------------------------------------------------------------
module tb_alu_stage;

    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpPass = 4'b0011;
    localparam logic [3:0] OpShr  = 4'b0100;
    localparam logic [3:0] OpMul  = 4'b0101;
    localparam logic [3:0] OpInc  = 4'b0110;
    localparam logic [3:0] OpClr  = 4'b0111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_stage_if #(.WIDTH(32)) bus ();

    alu_stage #(.WIDTH(32)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  en;
        logic        err;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural state the model carries between operations.
    logic [31:0] m_out = '0;
    logic        m_z   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
        int          guard;
        int          lat;
        logic        legal;
        logic [31:0] res;
        logic [63:0] prod;
        exp_t        e;

        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", guard);
        end

        legal = 1'b1;
        lat   = 0;
        res   = '0;
        prod  = 64'(a) * 64'(b);
        case (op)
            OpAdd:  res = a + b;
            OpSub:  res = a - b;
            OpPass: res = b;
            OpShr:  begin res = b >> a[4:0]; lat = int'(a[4:0]); end
            OpMul:  begin res = prod[31:0]; lat = 32; end
            OpInc:  res = a + 32'd1;
            OpClr:  res = '0;
            default: legal = 1'b0;
        endcase

        if (legal) begin
            m_out = res;
            m_z   = (res == 32'd0);
        end
        e.res = m_out;
        e.en  = legal ? sel : 4'b0000;
        e.err = !legal;
        e.z   = m_z;

        bus.abus_in  = a;
        bus.bbus_in  = b;
        bus.alu_op   = op;
        bus.cbus_sel = sel;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        e.cyc = cyc + lat;
        sb.push_back(e);
        bus.start    = 1'b0;
        // Scramble the inputs; the in-flight operation must not notice.
        bus.abus_in  = $urandom;
        bus.bbus_in  = $urandom;
        bus.alu_op   = 4'($urandom_range(0, 15));
        bus.cbus_sel = 4'($urandom_range(0, 15));
    endtask

    // Monitor
    initial begin
        logic [31:0] hold_out;
        logic        hold_z;
        logic        prev_done;
        exp_t        e;
        hold_out  = '0;
        hold_z    = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_cbus_out", bus.cbus_out, 32'd0);
                check("rst_cbus_en", 32'(bus.cbus_en), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_done", 32'(bus.done), 32'd0);
                check("rst_err", 32'(bus.err), 32'd0);
                check("rst_z_flag", 32'(bus.z_flag), 32'd0);
                hold_out  = '0;
                hold_z    = 1'b0;
                prev_done = 1'b0;
            end else if (bus.done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("wb_cbus_out", bus.cbus_out, e.res);
                    check("wb_cbus_en", 32'(bus.cbus_en), 32'(e.en));
                    check("wb_err", 32'(bus.err), 32'(e.err));
                    check("wb_z_flag", 32'(bus.z_flag), 32'(e.z));
                    check("wb_cycle", cyc, e.cyc);
                    check("wb_busy", 32'(bus.busy), 32'd1);
                    hold_out = e.res;
                    hold_z   = e.z;
                end
                prev_done = 1'b1;
            end else begin
                check("idle_cbus_en", 32'(bus.cbus_en), 32'd0);
                check("idle_err", 32'(bus.err), 32'd0);
                check("hold_cbus_out", bus.cbus_out, hold_out);
                check("hold_z_flag", 32'(bus.z_flag), 32'(hold_z));
                prev_done = 1'b0;
            end
        end
    end

    // Driver
    initial begin
        int guard;
        logic [3:0] op;

        bus.abus_in  = '0;
        bus.bbus_in  = '0;
        bus.alu_op   = 4'b0000;
        bus.cbus_sel = 4'b0000;
        bus.start    = 1'b0;

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        issue(OpAdd, 32'd5, 32'd7, 4'b0101);
        issue(OpSub, 32'd3, 32'd3, 4'b0101);
        issue(4'b1111, 32'd9, 32'd4, 4'b0110);
        issue(OpAdd, 32'hFFFF_FFFF, 32'd1, 4'b0101);
        issue(OpAdd, 32'd1, 32'd2, 4'b0000);
        issue(4'b0000, 32'd1, 32'd1, 4'b0011);
        issue(OpMul, 32'h0001_0001, 32'h0001_0001, 4'b0011);
        issue(OpShr, 32'd4, 32'h0000_00F0, 4'b0010);
        issue(OpShr, 32'd0, 32'h0000_00F0, 4'b0010);
        issue(OpShr, 32'd31, 32'h8000_0000, 4'b1000);
        issue(OpPass, 32'd0, 32'hDEAD_BEEF, 4'b1001);
        issue(OpInc, 32'hFFFF_FFFF, 32'd0, 4'b0001);
        issue(OpClr, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111);

        // start pulsed while a MUL is running must be ignored.
        issue(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100);
        repeat (5) @(negedge clk);
        bus.alu_op = OpAdd;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;

        // Reset in the middle of a MUL: operation aborted, nothing written.
        issue(OpMul, 32'h0000_0003, 32'h0000_0005, 4'b0111);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        m_out = '0;
        m_z   = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        issue(OpAdd, 32'd1, 32'd1, 4'b0001);

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
            else op = 4'($urandom_range(1, 7));
            issue(op, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end

        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
